// File: rtl/decade_cnt_arb.sv
// ============================================================================
// decade_cnt_arb : two-requester round-robin arbiter in front of a shared
//                  0..target counter with per-requester done pulses.
// Optional feature: define DCNT_PAUSE_EN to add the pause (count stall) port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decade_cnt_arb #(
   parameter int MAX_CNT = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [3:0] tgt0,
   input  logic       req1,
   input  logic [3:0] tgt1,
`ifdef DCNT_PAUSE_EN
   input  logic       pause,
`endif
   output logic       gnt0,
   output logic       gnt1,
   output logic [3:0] cnt,
   output logic       vld,
   output logic       done0,
   output logic       done1,
   output logic       busy
);

   localparam logic [3:0] C_MAX = 4'(MAX_CNT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [3:0] r_tgt;
   logic       r_rr_pri;   // requester that wins a tie: 0 or 1
   logic       w_any;
   logic       w_pick;
   logic       w_stall;
   logic [3:0] w_tgt0_c;
   logic [3:0] w_tgt1_c;

`ifdef DCNT_PAUSE_EN
   assign w_stall = pause;
`else
   assign w_stall = 1'b0;
`endif

   assign w_any    = req0 | req1;
   assign w_pick   = (req0 & req1) ? r_rr_pri : req1;
   assign w_tgt0_c = (tgt0 > C_MAX) ? C_MAX : tgt0;
   assign w_tgt1_c = (tgt1 > C_MAX) ? C_MAX : tgt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_tgt    <= 4'd0;
         r_rr_pri <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         cnt      <= 4'd0;
         vld      <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state  <= S_RUN;
                  gnt0     <= ~w_pick;
                  gnt1     <= w_pick;
                  r_rr_pri <= ~w_pick;
                  r_tgt    <= w_pick ? w_tgt1_c : w_tgt0_c;
                  cnt      <= 4'd0;
                  vld      <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_RUN: begin
               // A stall holds cnt, so the completion check below sees the held value later
               if (w_stall) begin
                  vld <= 1'b0;
               end else if (cnt == r_tgt) begin
                  r_state <= S_DONE;
                  gnt0    <= 1'b0;
                  gnt1    <= 1'b0;
                  vld     <= 1'b0;
                  cnt     <= 4'd0;
                  done0   <= gnt0;
                  done1   <= gnt1;
               end else begin
                  cnt <= cnt + 4'd1;
                  vld <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decade_cnt_arb.sv
// ============================================================================
// tb_decade_cnt_arb : scoreboard bench for decade_cnt_arb (per-cycle expected
//                     output records queued at stimulus time, popped each cycle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decade_cnt_arb;

   localparam int MAXC = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [3:0] tgt0, tgt1;
`ifdef DCNT_PAUSE_EN
   logic       pause;
`endif
   logic       gnt0, gnt1, vld, done0, done1, busy;
   logic [3:0] cnt;

   int n_vec = 0;
   int n_err = 0;

   // {gnt0, gnt1, cnt[3:0], vld, done0, done1, busy}
   logic [9:0] sb[$];
   wire  [9:0] obs = {gnt0, gnt1, cnt, vld, done0, done1, busy};

   always #5 clk = ~clk;

   decade_cnt_arb #(.MAX_CNT(MAXC)) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .tgt0  (tgt0),
      .req1  (req1),
      .tgt1  (tgt1),
`ifdef DCNT_PAUSE_EN
      .pause (pause),
`endif
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .cnt   (cnt),
      .vld   (vld),
      .done0 (done0),
      .done1 (done1),
      .busy  (busy)
   );

   function automatic logic [9:0] pk(bit g0, bit g1, int c, bit v, bit d0, bit d1, bit b);
      logic [3:0] c4;
      c4 = 4'(c);
      return {g0, g1, c4, v, d0, d1, b};
   endfunction

   // One complete run: target+1 live cycles, the DONE cycle, then one IDLE cycle.
   function automatic void push_run(int owner, int t);
      for (int i = 0; i <= t; i++)
         sb.push_back(pk(owner == 0, owner == 1, i, 1'b1, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b0, 1'b0, 0, 1'b0, owner == 0, owner == 1, 1'b1));
      sb.push_back(pk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
   endfunction

   task automatic test_reset();
      @(posedge clk); #1;
      n_vec++;
      if (obs !== 10'd0) begin
         n_err++;
         $display("FAIL reset: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", obs, 10'd0);
      end
      rst = 1'b0;
   endtask

   task automatic pulse_reset(string name);
      rst = 1'b1;
      #1;
      n_vec++;
      if (obs !== 10'd0) begin
         n_err++;
         $display("FAIL %s: outputs during rst got %b want %b", name, obs, 10'd0);
      end
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      logic [9:0] e;
      req0 = 1'b1; tgt0 = 4'd3;
      push_run(0, 3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL single[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         // request drop and target change mid-run must not disturb the run
         if (i == 0) begin req0 = 1'b0; tgt0 = 4'd7; end
      end
   endtask

   task automatic test_round_robin();
      logic [9:0] e;
      pulse_reset("rr_reset");
      req0 = 1'b1; req1 = 1'b1; tgt0 = 4'd2; tgt1 = 4'd1;
      push_run(0, 2); push_run(1, 1); push_run(0, 2); push_run(1, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL round_robin[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         if (sb.size() == 1) begin req0 = 1'b0; req1 = 1'b0; end
      end
   endtask

   task automatic test_clamp();
      logic [9:0] e;
      req1 = 1'b1; tgt1 = 4'hF;
      push_run(1, MAXC);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL clamp[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         if (i == 0) req1 = 1'b0;
      end
   endtask

   task automatic test_zero_target();
      logic [9:0] e;
      req0 = 1'b1; tgt0 = 4'd0;
      push_run(0, 0);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL zero_tgt[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         if (i == 0) req0 = 1'b0;
      end
   endtask

   task automatic test_reset_mid_run();
      logic [9:0] e;
      req0 = 1'b1; tgt0 = 4'd8;
      for (int i = 0; i <= 5; i++)
         sb.push_back(pk(1'b1, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b1));
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL mid_rst_pre[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
      end
      pulse_reset("mid_rst_abort");
      push_run(0, 8);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL mid_rst_post[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         if (i == 0) req0 = 1'b0;
      end
   endtask

`ifdef DCNT_PAUSE_EN
   task automatic test_pause();
      logic [9:0] e;
      req0 = 1'b1; tgt0 = 4'd4;
      for (int i = 0; i <= 2; i++)
         sb.push_back(pk(1'b1, 1'b0, i, 1'b1, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1));
      sb.push_back(pk(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1));
      sb.push_back(pk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL pause[%0d]: {g0,g1,cnt,vld,d0,d1,busy} got %b want %b", i, obs, e);
         end
         if (i == 0) req0 = 1'b0;
         if (i == 2) pause = 1'b1;
         if (i == 4) pause = 1'b0;
      end
   endtask
`endif

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tgt0 = 4'd0; tgt1 = 4'd0;
`ifdef DCNT_PAUSE_EN
      pause = 1'b0;
`endif
      test_reset();
      test_single();
      test_round_robin();
      test_clamp();
      test_zero_target();
      test_reset_mid_run();
`ifdef DCNT_PAUSE_EN
      test_pause();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decade_cnt_arb.md
DECADE_CNT_ARB -- requirements
Module: decade_cnt_arb

Interface
REQ-001 The block SHALL have parameter MAX_CNT, default 9, meaning the highest count value and the clamp limit for targets (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port req0, input, 1, run request from requester 0 (level).
REQ-005 The block SHALL have port tgt0, input, 4, final count for requester 0, sampled at grant.
REQ-006 The block SHALL have port req1, input, 1, run request from requester 1 (level).
REQ-007 The block SHALL have port tgt1, input, 4, final count for requester 1, sampled at grant.
REQ-008 The block SHALL have port pause, input, 1, count stall; present only under DCNT_PAUSE_EN.
REQ-009 The block SHALL have port gnt0, output, 1, requester 0 owns the counter.
REQ-010 The block SHALL have port gnt1, output, 1, requester 1 owns the counter.
REQ-011 The block SHALL have port cnt, output, 4, the shared counter value.
REQ-012 The block SHALL have port vld, output, 1, cnt is a live count step for the granted requester.
REQ-013 The block SHALL have port done0, output, 1, one-cycle pulse: requester 0 run finished.
REQ-014 The block SHALL have port done1, output, 1, one-cycle pulse: requester 1 run finished.
REQ-015 The block SHALL have port busy, output, 1, high in RUN and DONE states.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; all outputs registered.
REQ-017 In IDLE with any req high at an edge, the block SHALL grant one requester, latch its target (values >MAX_CNT clamped to MAX_CNT), and enter RUN with gntX=1, cnt=0, vld=1 after that edge.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; the pointer updates only at a grant.
REQ-019 In RUN, each edge SHALL increment cnt by 1 while cnt != latched target; gnt stays one-hot and constant.
REQ-020 At an edge in RUN with cnt == target, the block SHALL enter DONE: gnt low, vld 0, cnt 0, doneX=1 for the finished requester.
REQ-021 DONE SHALL last exactly one cycle, then IDLE; requests are not sampled in DONE.
REQ-022 A run SHALL present vld=1 for exactly target+1 cycles with cnt 0,1,...,target; target 0 gives one cycle at cnt=0.
REQ-023 cnt SHALL never exceed MAX_CNT and SHALL never wrap inside a run.
REQ-024 Deasserting req or changing tgt during RUN SHALL be ignored; the run completes.
REQ-025 gnt0 and gnt1 SHALL never be high together; done0/done1 SHALL never be high together.

Reset
REQ-026 While rst is high the block SHALL asynchronously force IDLE, cnt=0, vld=0, gnt0=gnt1=0, done0=done1=0, busy=0, RR pointer favouring requester 0.
REQ-027 Reset asserted mid-run SHALL abort the run without any done pulse; first grant after release follows REQ-017.

Configuration
REQ-028 With macro DCNT_PAUSE_EN defined, pause high at an edge in RUN SHALL hold cnt and drive vld=0 for that cycle; completion check uses the held cnt; pause has no effect in IDLE/DONE.
REQ-029 Without DCNT_PAUSE_EN the pause port SHALL be absent and RUN never stalls.

Verification
REQ-030 req0=1, tgt0=3 from reset -> gnt0 after 1st edge, cnt 0,1,2,3 with vld=1, then done0 pulse, busy low one cycle later.
REQ-031 req0=req1=1 held, tgt0=2, tgt1=1 -> grant order 0,1,0,1; done pulses alternate; gnts never overlap.
REQ-032 tgt1=4'hF, req1 only -> cnt runs 0..9 (10 vld cycles), done1, no wrap.
REQ-033 tgt0=0 -> single vld cycle with cnt=0, done0 next cycle.
REQ-034 rst pulsed at cnt=5 of a tgt=8 run -> all outputs zero immediately, no done pulse, fresh run starts at cnt=0.
REQ-035 DCNT_PAUSE_EN, tgt0=4, pause high for 2 cycles at cnt=2 -> cnt holds 2, vld=0 two cycles, run ends at 4 with done0.
